spi_slave_param: RTL and testbench
==================================

Name: spi_slave_param

Overview:
- Parametrised next-generation SPI slave between an external SPI master and the single-port RAM controller.
- Deserialises framed MOSI commands of configurable payload width into parallel rx_data words with a one-cycle rx_valid strobe.
- Enforces read-address / read-data command ordering and flags protocol errors.
- Serialises RAM read data onto MISO after an explicit tx_valid handshake.

Parameters:
- PAYLOAD_W, 8, payload bits per frame; frame width FRAME_W = PAYLOAD_W+2 (2 command bits + payload).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- SS_n  in  1  slave select, active low; frame boundary.
- MOSI  in  1  serial data from master, MSB first.
- tx_valid  in  1  RAM read data valid strobe.
- tx_data  in  PAYLOAD_W  RAM read data.
- MISO  out  1  serial data to master, MSB first.
- rx_valid  out  1  one-cycle strobe: rx_data holds a complete legal frame.
- rx_data  out  PAYLOAD_W+2  {cmd[1:0], payload}; cmd 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
- frame_err  out  1  one-cycle strobe on command-order violation.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, MISO=0, rx_valid=0, rx_data=0, frame_err=0, busy=0, rd_pending=0, counters 0. rst has priority over all other inputs.
- Edge numbering: edge 0 is the edge at which IDLE samples SS_n=0 (IDLE->CHK_CMD).
- MOSI sampling: one bit per edge at edges 1..FRAME_W, shifted MSB first.
- States and transitions:
  - IDLE -> CHK_CMD when SS_n=0.
  - CHK_CMD samples cmd[1]. 0 -> WRITE. 1 with rd_pending=0 -> READ_ADD. 1 with rd_pending=1 -> READ_DATA.
  - WRITE / READ_ADD / READ_DATA sample the remaining FRAME_W-1 bits.
  - The second bit (cmd[0]) is checked in READ_ADD (must be 0) and READ_DATA (must be 1). On mismatch: frame_err pulses one cycle, go to HOLD, no rx_valid, rd_pending unchanged.
  - After the last bit, rx_data <= full frame and rx_valid=1 for exactly the cycle after edge FRAME_W+1.
  - WRITE -> HOLD. READ_ADD -> HOLD and sets rd_pending. READ_DATA -> READ_WAIT and clears rd_pending.
  - READ_WAIT: ignore MOSI. On tx_valid=1, latch tx_data; MISO = tx_data[PAYLOAD_W-1] from that edge; -> SEND.
  - SEND: shift out one bit per edge, MSB first; after PAYLOAD_W bits, MISO=0 -> HOLD.
  - HOLD: ignore MOSI and tx_valid until SS_n=1.
- SS_n=1 in any non-IDLE state, checked at every edge: -> IDLE at that edge.
  - Partial frame is discarded: no rx_valid, rx_data keeps its old value, counters cleared, MISO=0.
  - rd_pending is unchanged unless the frame already completed.
- tx_valid outside READ_WAIT is ignored. tx_valid during SEND does not restart the shift.
- MISO is 0 in every state except SEND.
- Counters: bit counter width $clog2(FRAME_W+1); no wrap-around permitted within a frame.
- rx_valid and frame_err are never high in the same cycle.

Test Plan:
- Write address: PAYLOAD_W=8, SS_n low, MOSI 00_0101_1010, SS_n high -> rx_data=10'h05A, rx_valid high exactly 1 cycle, frame_err=0, MISO=0 throughout.
- Read sequence:
  - Frame 10_0011_0011 -> rx_data=10'h233, rx_valid pulse.
  - Frame 11_0000_0000 -> rx_data=10'h300, rx_valid pulse.
  - tx_valid=1 with tx_data=8'hA5 -> MISO 1,0,1,0,0,1,0,1 on 8 consecutive cycles, then 0.
- Ordering errors:
  - Frame 11_xxxx_xxxx after reset (rd_pending=0) -> frame_err pulse, no rx_valid.
  - Frame 10_0000_0001, then frame 10_x -> second frame gives frame_err.
- Abort: SS_n high after 5 bits of a write frame -> no rx_valid, state IDLE next cycle; the following full frame 01_1111_0000 -> rx_data=10'h1F0.
- Reset mid-transfer: rst=1 during SEND after 3 bits -> next cycle MISO=0, busy=0, rx_valid=0, rd_pending=0; then 11_x frame -> frame_err.
- Width: PAYLOAD_W=16, frame 01_BEEF, then read sequence with tx_data=16'hC3C3 -> rx_data=18'h1BEEF, 16 MISO bits MSB first.

Source files
------------

// File: rtl/spi_slave_param.sv
// SPI slave: deserialises {cmd, payload} frames from the master, enforces
// read-address / read-data ordering and shifts RAM read data out on MISO.
module spi_slave_param #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  input  logic                 tx_valid,
  input  logic [PAYLOAD_W-1:0] tx_data,
  output logic                 MISO,
  output logic                 rx_valid,
  output logic [PAYLOAD_W+1:0] rx_data,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int FRAME_W = PAYLOAD_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] F_LAST = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PAYLOAD_W);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, READ_WAIT, SEND, HOLD
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [FRAME_W-1:0]   rx_sh;
  logic [PAYLOAD_W-1:0] tx_sh;
  logic                 rd_pending;
  logic                 in_frame;

  assign in_frame = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      rd_pending <= 1'b0;
      MISO       <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (state != IDLE && SS_n) begin
        state   <= IDLE;
        bit_cnt <= '0;
        MISO    <= 1'b0;
        // every bit already sampled: the frame counts even as SS_n rises
        if (in_frame && bit_cnt == F_LAST) begin
          rx_data  <= rx_sh;
          rx_valid <= 1'b1;
          if (state == READ_ADD)  rd_pending <= 1'b1;
          if (state == READ_DATA) rd_pending <= 1'b0;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (!SS_n) begin
              state   <= CHK_CMD;
              bit_cnt <= '0;
            end
          end
          CHK_CMD: begin
            rx_sh   <= {rx_sh[FRAME_W-2:0], MOSI};
            bit_cnt <= CNT_W'(1);
            if (!MOSI)          state <= WRITE;
            else if (rd_pending) state <= READ_DATA;
            else                 state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (bit_cnt == F_LAST) begin
              rx_data  <= rx_sh;
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
              if (state == READ_DATA) begin
                state      <= READ_WAIT;
                rd_pending <= 1'b0;
              end else begin
                state <= HOLD;
                if (state == READ_ADD) rd_pending <= 1'b1;
              end
            end else if (bit_cnt == CNT_W'(1) &&
                         ((state == READ_ADD && MOSI) || (state == READ_DATA && !MOSI))) begin
              frame_err <= 1'b1;
              state     <= HOLD;
              bit_cnt   <= '0;
            end else begin
              rx_sh   <= {rx_sh[FRAME_W-2:0], MOSI};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          READ_WAIT: begin
            if (tx_valid) begin
              MISO    <= tx_data[PAYLOAD_W-1];
              tx_sh   <= {tx_data[PAYLOAD_W-2:0], 1'b0};
              bit_cnt <= CNT_W'(1);
              state   <= SEND;
            end
          end
          SEND: begin
            if (bit_cnt == P_LAST) begin
              MISO    <= 1'b0;
              bit_cnt <= '0;
              state   <= HOLD;
            end else begin
              MISO    <= tx_sh[PAYLOAD_W-1];
              tx_sh   <= {tx_sh[PAYLOAD_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          HOLD: ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: 8-bit and 16-bit payload instances
// share the serial stimulus; sel16 selects which one is observed.
module tb_spi_slave_param;
  logic clk = 1'b0;
  logic rst, ss_n, mosi, tx_valid;
  logic [7:0]  tx_data8;
  logic [15:0] tx_data16;
  logic miso8, rxv8, fe8, busy8, miso16, rxv16, fe16, busy16;
  logic [9:0]  rxd8;
  logic [17:0] rxd16;
  logic sel16 = 1'b0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  spi_slave_param #(.PAYLOAD_W(8)) dut8 (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .tx_valid(tx_valid),
    .tx_data(tx_data8), .MISO(miso8), .rx_valid(rxv8), .rx_data(rxd8),
    .frame_err(fe8), .busy(busy8));

  spi_slave_param #(.PAYLOAD_W(16)) dut16 (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .tx_valid(tx_valid),
    .tx_data(tx_data16), .MISO(miso16), .rx_valid(rxv16), .rx_data(rxd16),
    .frame_err(fe16), .busy(busy16));

  logic o_miso, o_rxv, o_fe, o_busy;
  logic [17:0] o_rxd;
  assign o_miso = sel16 ? miso16 : miso8;
  assign o_rxv  = sel16 ? rxv16  : rxv8;
  assign o_fe   = sel16 ? fe16   : fe8;
  assign o_busy = sel16 ? busy16 : busy8;
  assign o_rxd  = sel16 ? rxd16  : {8'b0, rxd8};

  typedef struct {
    logic [9:0] frame;
    bit         exp_err;
    logic [9:0] exp_data;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives edge 0 plus nbits MOSI bits; a complete frame keeps SS_n low for
  // two further edges. Samples after every edge (cycle index = edge number).
  task automatic run_frame(input logic [17:0] bits, input int fw, input int nbits,
                           input bit keep_low, output int v_cyc, output int v_cnt,
                           output int e_cyc, output int e_cnt, output int miso_hi,
                           output logic busy_after);
    int low_edges;
    v_cyc = -1; e_cyc = -1; v_cnt = 0; e_cnt = 0; miso_hi = 0; busy_after = 1'b0;
    low_edges = (nbits == fw) ? fw + 3 : nbits + 1;
    for (int e = 0; e < low_edges; e++) begin
      ss_n = 1'b0;
      mosi = (e >= 1 && e <= nbits) ? bits[fw-e] : 1'b0;
      @(negedge clk);
      if (o_rxv) begin v_cnt++; if (v_cyc < 0) v_cyc = e; end
      if (o_fe)  begin e_cnt++; if (e_cyc < 0) e_cyc = e; end
      if (o_miso) miso_hi++;
    end
    if (!keep_low) begin
      for (int h = 0; h < 2; h++) begin
        ss_n = 1'b1; mosi = 1'b0;
        @(negedge clk);
        if (h == 0) busy_after = o_busy;
        if (o_rxv) v_cnt++;
        if (o_fe)  e_cnt++;
        if (o_miso) miso_hi++;
      end
    end
  endtask

  task automatic frame_ok(input string name, input logic [17:0] bits, input int fw,
                          input bit keep_low);
    int vc, vn, ec, en, mh; logic ba;
    run_frame(bits, fw, fw, keep_low, vc, vn, ec, en, mh, ba);
    chk({name, " rx_valid cycle"}, vc, fw + 1);
    chk({name, " rx_valid count"}, vn, 1);
    chk({name, " frame_err count"}, en, 0);
    chk({name, " rx_data"}, o_rxd, bits);
  endtask

  // Shift-out check; a second tx_valid mid-SEND must not restart the shift,
  // or with do_rst the block is reset after three bits.
  task automatic send_check(input logic [15:0] d, input int w, input bit do_rst);
    tx_valid = 1'b1; tx_data8 = d[7:0]; tx_data16 = d;
    for (int i = 0; i <= w; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      chk($sformatf("miso bit %0d", i), o_miso, (i < w) ? d[w-1-i] : 1'b0);
      if (i == 2) begin
        if (do_rst) begin
          rst = 1'b1;
          @(negedge clk);
          chk("rst mid miso", o_miso, 0);
          chk("rst mid busy", o_busy, 0);
          chk("rst mid rx_valid", o_rxv, 0);
          chk("rst mid rx_data", o_rxd, 0);
          rst = 1'b0; ss_n = 1'b1;
          @(negedge clk);
          return;
        end
        tx_valid = 1'b1; tx_data8 = 8'h00; tx_data16 = 16'h0000;
      end
    end
    chk("send done busy", o_busy, 1);
    ss_n = 1'b1;
    @(negedge clk);
    chk("send end busy", o_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc, vn, ec, en, mh; logic ba;
    tbl[0] = '{10'b00_0101_1010, 1'b0, 10'h05A};
    tbl[1] = '{10'b11_0000_0000, 1'b1, 10'h05A};
    tbl[2] = '{10'b10_0011_0011, 1'b0, 10'h233};
    tbl[3] = '{10'b10_0000_0001, 1'b1, 10'h233};
    tbl[4] = '{10'b11_0000_0000, 1'b0, 10'h300};
    tbl[5] = '{10'b01_1111_0000, 1'b0, 10'h1F0};
    tbl[6] = '{10'b10_0000_0001, 1'b0, 10'h201};
    tbl[7] = '{10'b10_1010_1010, 1'b1, 10'h201};
    tx_data8 = 8'h00; tx_data16 = 16'h0000;

    @(negedge clk);
    do_reset();
    chk("reset miso", o_miso, 0);
    chk("reset rx_valid", o_rxv, 0);
    chk("reset rx_data", o_rxd, 0);
    chk("reset frame_err", o_fe, 0);
    chk("reset busy", o_busy, 0);

    for (int i = 0; i < 8; i++) begin
      run_frame({8'b0, tbl[i].frame}, 10, 10, 1'b0, vc, vn, ec, en, mh, ba);
      chk($sformatf("vec%0d rx_valid count", i), vn, tbl[i].exp_err ? 0 : 1);
      chk($sformatf("vec%0d frame_err count", i), en, tbl[i].exp_err ? 1 : 0);
      if (tbl[i].exp_err) chk($sformatf("vec%0d frame_err cycle", i), ec, 2);
      else                chk($sformatf("vec%0d rx_valid cycle", i), vc, 11);
      chk($sformatf("vec%0d rx_data", i), o_rxd, {8'b0, tbl[i].exp_data});
      chk($sformatf("vec%0d miso quiet", i), mh, 0);
      chk($sformatf("vec%0d busy after ss_n", i), ba, 0);
    end

    do_reset();
    frame_ok("rd addr", 18'h233, 10, 1'b0);
    frame_ok("rd data", 18'h300, 10, 1'b1);
    send_check(16'h00A5, 8, 1'b0);

    run_frame(18'h05A, 10, 5, 1'b0, vc, vn, ec, en, mh, ba);
    chk("abort rx_valid count", vn, 0);
    chk("abort busy", ba, 0);
    chk("abort rx_data kept", o_rxd, 18'h300);
    frame_ok("after abort", 18'h1F0, 10, 1'b0);

    frame_ok("rst rd addr", 18'h233, 10, 1'b0);
    frame_ok("rst rd data", 18'h300, 10, 1'b1);
    send_check(16'h00A5, 8, 1'b1);
    run_frame(18'h300, 10, 10, 1'b0, vc, vn, ec, en, mh, ba);
    chk("post rst rd data err", en, 1);
    chk("post rst rd data no valid", vn, 0);

    sel16 = 1'b1;
    do_reset();
    chk("w16 reset rx_data", o_rxd, 0);
    frame_ok("w16 write", 18'h1BEEF, 18, 1'b0);
    frame_ok("w16 rd addr", {2'b10, 16'h1234}, 18, 1'b0);
    frame_ok("w16 rd data", {2'b11, 16'h0000}, 18, 1'b1);
    send_check(16'hC3C3, 16, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
